// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encodings, command codes and next-state helper for the TAP responder.
package jtag_pkg;
  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0, EXIT1_DR = 4'h1, SHIFT_DR = 4'h2, PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4, UPD_DR   = 4'h5, CAP_DR   = 4'h6, SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8, EXIT1_IR = 4'h9, SHIFT_IR = 4'hA, PAUSE_IR = 4'hB,
    RTI      = 4'hC, UPD_IR   = 4'hD, CAP_IR   = 4'hE, TLR      = 4'hF
  } tap_state_e;
  typedef enum logic [1:0] {PH_IDLE, PH_ADDR, PH_WRITE, PH_READ} cmd_phase_e;
  localparam logic [7:0] CMD_SET_ADDR = 8'h9A;
  localparam logic [7:0] CMD_WRITE    = 8'h9B;
  localparam logic [7:0] CMD_READ     = 8'h9D;
  localparam logic [7:0] JTAG_ID_DEF  = 8'h89;
  localparam logic [7:0] IR_ADDR_DEF  = 8'h09;
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TLR:      return tms ? TLR      : RTI;
      RTI:      return tms ? SEL_DR   : RTI;
      SEL_DR:   return tms ? SEL_IR   : CAP_DR;
      CAP_DR:   return tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: return tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: return tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: return tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   return tms ? SEL_DR   : RTI;
      SEL_IR:   return tms ? TLR      : CAP_IR;
      CAP_IR:   return tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: return tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: return tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: return tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   return tms ? SEL_DR   : RTI;
      default:  return TLR;
    endcase
  endfunction
endpackage

// File: rtl/jtag_tap_responder_sync.sv
// jtag_edge_sync: synchronises tck/tms/tdi into clk and emits one-cycle tck rise/fall pulses.
module jtag_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tck_rise_o,
  output logic tck_fall_o,
  output logic tms_o,
  output logic tdi_o
);
  logic [STAGES-1:0] tck_q, tms_q, tdi_q;
  logic              tck_prev_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_q      <= '0;
      tms_q      <= '0;
      tdi_q      <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      tck_q      <= {tck_q[STAGES-2:0], tck_i};
      tms_q      <= {tms_q[STAGES-2:0], tms_i};
      tdi_q      <= {tdi_q[STAGES-2:0], tdi_i};
      tck_prev_q <= tck_q[STAGES-1];
    end
  end
  assign tck_rise_o = tck_q[STAGES-1] & ~tck_prev_q;
  assign tck_fall_o = ~tck_q[STAGES-1] & tck_prev_q;
  assign tms_o      = tms_q[STAGES-1];
  assign tdi_o      = tdi_q[STAGES-1];
endmodule

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: oversampled IEEE 1149.1 TAP with an 8-bit IR and a 16-bit
// command/data DR giving JTAG set-address/write/read access to a 16x16 register file.
module jtag_tap_responder
  import jtag_pkg::*;
#(
  parameter logic [7:0] JTAG_ID     = JTAG_ID_DEF,
  parameter logic [7:0] IR_ADDR     = IR_ADDR_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tck_i,
  input  logic        tms_i,
  input  logic        tdi_i,
  output logic        tdo_o,
  output logic        tdo_oe_o,
  input  logic        host_we_i,
  input  logic [3:0]  host_addr_i,
  input  logic [15:0] host_wdata_i,
  output logic [15:0] host_rdata_o,
  output logic [7:0]  ir_o,
  output logic [3:0]  tap_state_o,
  output logic        cmd_err_o
);
  logic        rise, fall, tms, tdi, byp, jt_we;
  tap_state_e  state_q, state_d;
  cmd_phase_e  phase_q, phase_d;
  logic [7:0]  ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic [15:0] dr_sr_q, dr_sr_d, host_rdata_q;
  logic [3:0]  idx_q, idx_d;
  logic        cmd_err_q, cmd_err_d, tdo_q, tdo_d, oe_q, oe_d;
  logic [15:0] rf_q [16];

  jtag_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .tck_i      (tck_i),
    .tms_i      (tms_i),
    .tdi_i      (tdi_i),
    .tck_rise_o (rise),
    .tck_fall_o (fall),
    .tms_o      (tms),
    .tdi_o      (tdi)
  );

  assign byp = ir_q != IR_ADDR;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= TLR;
      phase_q      <= PH_IDLE;
      ir_q         <= IR_ADDR;
      ir_sr_q      <= '0;
      dr_sr_q      <= '0;
      idx_q        <= '0;
      cmd_err_q    <= 1'b0;
      tdo_q        <= 1'b0;
      oe_q         <= 1'b0;
      host_rdata_q <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      ir_q         <= ir_d;
      ir_sr_q      <= ir_sr_d;
      dr_sr_q      <= dr_sr_d;
      idx_q        <= idx_d;
      cmd_err_q    <= cmd_err_d;
      tdo_q        <= tdo_d;
      oe_q         <= oe_d;
      host_rdata_q <= rf_q[host_addr_i];
      // JTAG write takes precedence only on a shared index; distinct indices both land
      for (int i = 0; i < 16; i++)
        if (jt_we && idx_q == 4'(i)) rf_q[i] <= dr_sr_q;
        else if (host_we_i && host_addr_i == 4'(i)) rf_q[i] <= host_wdata_i;
    end
  end

  always_comb begin
    state_d   = rise ? tap_next(state_q, tms) : state_q;
    phase_d   = phase_q;
    ir_d      = ir_q;
    ir_sr_d   = ir_sr_q;
    dr_sr_d   = dr_sr_q;
    idx_d     = idx_q;
    cmd_err_d = cmd_err_q;
    tdo_d     = tdo_q;
    oe_d      = oe_q;
    jt_we     = 1'b0;
    if (rise) begin
      if (state_q == SHIFT_IR) ir_sr_d = {ir_sr_q[6:0], tdi};
      if (state_q == SHIFT_DR) dr_sr_d = byp ? {15'b0, tdi} : {dr_sr_q[14:0], tdi};
      if (state_d == CAP_IR) ir_sr_d = JTAG_ID;
      if (state_d == CAP_DR) dr_sr_d = (!byp && phase_q == PH_READ) ? rf_q[idx_q] : '0;
      if (state_d == UPD_IR) begin
        ir_d    = ir_sr_q;
        phase_d = PH_IDLE;
      end
      if (state_d == UPD_DR && !byp) begin
        phase_d = PH_IDLE;
        if (phase_q == PH_IDLE) begin
          phase_d   = dr_sr_q == {8'h00, CMD_SET_ADDR} ? PH_ADDR :
                      dr_sr_q == {8'h00, CMD_WRITE}    ? PH_WRITE :
                      dr_sr_q == {8'h00, CMD_READ}     ? PH_READ : PH_IDLE;
          cmd_err_d = cmd_err_q | (phase_d == PH_IDLE);
        end
        if (phase_q == PH_ADDR) idx_d = dr_sr_q[4:1];
        jt_we = phase_q == PH_WRITE;
      end
      if (state_d == TLR) begin
        ir_d    = IR_ADDR;
        phase_d = PH_IDLE;
      end
    end
    if (fall) begin
      tdo_d = state_q == SHIFT_IR ? ir_sr_q[7] :
              state_q == SHIFT_DR ? (byp ? dr_sr_q[0] : dr_sr_q[15]) : 1'b0;
      oe_d  = state_q == SHIFT_IR || state_q == SHIFT_DR;
    end
  end

  assign tdo_o        = tdo_q;
  assign tdo_oe_o     = oe_q;
  assign host_rdata_o = host_rdata_q;
  assign ir_o         = ir_q;
  assign tap_state_o  = state_q;
  assign cmd_err_o    = cmd_err_q;
endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder: directed JTAG scans against the TAP responder with hand-computed expectations.
module tb_jtag_tap_responder;
  logic        clk = 1'b0, rst_n = 1'b0, tck = 1'b0, tms = 1'b1, tdi = 1'b0;
  logic        host_we = 1'b0;
  logic [3:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        tdo, tdo_oe, cmd_err;
  logic [15:0] host_rdata, out;
  logic [7:0]  ir;
  logic [3:0]  tap_state;
  logic        s_tdo, s_oe;
  int          checks = 0, errors = 0, oe_cnt = 0;

  jtag_tap_responder dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tck_i        (tck),
    .tms_i        (tms),
    .tdi_i        (tdi),
    .tdo_o        (tdo),
    .tdo_oe_o     (tdo_oe),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_rdata_o (host_rdata),
    .ir_o         (ir),
    .tap_state_o  (tap_state),
    .cmd_err_o    (cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // tdo/tdo_oe are sampled just before each rise, reflecting the previous fall
  task automatic tck_cycle(input logic m, input logic d);
    tms = m;
    tdi = d;
    repeat (4) @(negedge clk);
    s_tdo = tdo;
    s_oe  = tdo_oe;
    oe_cnt += int'(s_oe);
    tck = 1'b1;
    repeat (8) @(negedge clk);
    tck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic scan(input logic is_ir, input logic [15:0] v, output logic [15:0] o);
    int n = is_ir ? 8 : 16;
    oe_cnt = 0;
    o = '0;
    tck_cycle(1'b1, 1'b0);
    if (is_ir) tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, v[n-1-i]);
      o = {o[14:0], s_tdo};
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  task automatic dr(input logic [15:0] v);
    scan(1'b0, v, out);
  endtask

  task automatic jtag_read(input logic [7:0] a);
    dr(16'h009A);
    dr({8'h00, a});
    dr(16'h009D);
    dr(16'h0000);
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [15:0] d);
    host_we = 1'b1;
    host_addr = a;
    host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [3:0] a);
    host_addr = a;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tdo", 32'(tdo), 32'h0);
    chk("rst_oe", 32'(tdo_oe), 32'h0);
    chk("rst_state", 32'(tap_state), 32'hF);
    chk("rst_ir", 32'(ir), 32'h09);
    chk("rst_err", 32'(cmd_err), 32'h0);
    chk("rst_rdata", 32'(host_rdata), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    chk("tlr_hold", 32'(tap_state), 32'hF);
    tck_cycle(1'b0, 1'b0);
    chk("rti", 32'(tap_state), 32'hC);

    scan(1'b1, 16'h0009, out);
    chk("ir_out", 32'(out[7:0]), 32'h89);
    chk("ir_oe_bits", 32'(oe_cnt), 32'd8);
    chk("ir_upd", 32'(ir), 32'h09);
    chk("ir_rti", 32'(tap_state), 32'hC);

    host_wr(4'd1, 16'h0001);
    host_rd(4'd1);
    chk("host_rd1", 32'(host_rdata), 32'h0001);
    dr(16'h009A);
    chk("idle_cap0", 32'(out), 32'h0);
    chk("dr_oe_bits", 32'(oe_cnt), 32'd16);
    dr(16'h0002);
    dr(16'h009D);
    dr(16'h0000);
    chk("read_idx1", 32'(out), 32'h0001);

    dr(16'h009A);
    dr(16'h001C);
    dr(16'h009B);
    dr(16'hBEEF);
    host_rd(4'd14);
    chk("host_rd14", 32'(host_rdata), 32'hBEEF);
    jtag_read(8'h1C);
    chk("read_1c", 32'(out), 32'hBEEF);
    chk("no_err", 32'(cmd_err), 32'h0);

    dr(16'h0055);
    chk("err_set", 32'(cmd_err), 32'h1);
    jtag_read(8'h22);
    chk("wrap_22", 32'(out), 32'h0001);
    chk("err_sticky", 32'(cmd_err), 32'h1);

    host_wr(4'd1, 16'h0000);
    host_wr(4'd0, 16'h1234);
    jtag_read(8'h02);
    chk("poll_flag0", 32'(out), 32'h0000);
    jtag_read(8'h00);
    chk("poll_data", 32'(out), 32'h1234);
    host_wr(4'd1, 16'h0001);
    jtag_read(8'h02);
    chk("poll_flag1", 32'(out), 32'h0001);

    scan(1'b1, 16'h0055, out);
    chk("ir_out2", 32'(out[7:0]), 32'h89);
    chk("ir_byp", 32'(ir), 32'h55);
    dr(16'h8001);
    chk("bypass", 32'(out), 32'h4000);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    chk("tlr_state", 32'(tap_state), 32'hF);
    chk("tlr_ir", 32'(ir), 32'h09);

    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1);
    chk("mid_shift", 32'(tap_state), 32'h2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_state", 32'(tap_state), 32'hF);
    chk("mrst_oe", 32'(tdo_oe), 32'h0);
    chk("mrst_err", 32'(cmd_err), 32'h0);
    rst_n = 1'b1;
    host_rd(4'd14);
    chk("mrst_rf", 32'(host_rdata), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_tap_responder.md
Name: jtag_tap_responder

Overview:
- Target-side JTAG TAP model. It is the responder for the FPGA's JTAG shift/poll engines.
- Oversamples tck/tms/tdi on the system clock and runs the IEEE 1149.1 16-state TAP FSM. Drives tdo from an 8-bit IR and a 16-bit DR.
- Implements the command protocol the watchpoint poller uses: IR 0x09, then DR command 0x9A (set address), 0x9B (write) or 0x9D (read), then the DR data word.
- Uses: loopback bench partner for the poller, and an on-board emulated target. A host port preloads the register file.

Parameters:
- JTAG_ID, 8'h89: value captured into IR at Capture-IR.
- IR_ADDR, 8'h09: instruction that selects the command/data DR path.
- SYNC_STAGES, 2: synchroniser depth on tck/tms/tdi (minimum 2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- tck  in  1  JTAG clock (asynchronous to clk).
- tms  in  1  JTAG mode select.
- tdi  in  1  JTAG data in.
- tdo  out  1  JTAG data out.
- tdo_oe  out  1  high while in Shift-IR/Shift-DR.
- host_we  in  1  write strobe for the register file.
- host_addr  in  4  register file index.
- host_wdata  in  16  host write data.
- host_rdata  out  16  registered read of regfile[host_addr], 1-cycle latency.
- ir  out  8  current latched instruction.
- tap_state  out  4  FSM state encoding (shared package).
- cmd_err  out  1  sticky; set on an unknown command word.

Behaviour:
- Reset (reset_n low) forces the following, immediately and asynchronously:
  - tap_state = Test-Logic-Reset; ir = IR_ADDR.
  - tdo = 0, tdo_oe = 0, cmd_err = 0, host_rdata = 0.
  - addr pointer = 0, cmd phase = IDLE.
  - The register file is cleared to 0.
- Reset mid-shift abandons the shift; no update occurs.
- Input sampling:
  - tck, tms and tdi pass through SYNC_STAGES flops.
  - tck rise/fall are detected from the last two synchronised samples, as one-cycle pulses.
  - tck high and low phases must each be at least SYNC_STAGES+1 clk cycles; behaviour is undefined otherwise.
- FSM:
  - Advances on a detected tck rise using the synchronised tms. All 16 states follow IEEE 1149.1.
  - tms = 1 for 5 consecutive rises reaches Test-Logic-Reset from any state. That state also sets ir = IR_ADDR and the cmd phase to IDLE.
- Shifting:
  - MSB first for both IR (8 bits) and DR (16 bits).
  - On a rise in Shift-xR, the shift register shifts left and takes tdi into the LSB.
  - On a fall, tdo = shift register MSB. Outside Shift-xR, tdo = 0 at each fall.
  - tdo_oe follows tap_state == Shift-IR or Shift-DR, updated on the fall.
  - Any shift length is accepted. Update uses the current register contents (short shift = partial value, long shift = last 16/8 bits).
- Capture:
  - Capture-IR loads JTAG_ID.
  - Capture-DR loads regfile[addr[4:1]] when the cmd phase is READ, otherwise 0.
  - When ir != IR_ADDR, the DR is a 1-bit bypass register captured as 0.
- Update-IR: ir = IR shift register; cmd phase = IDLE.
- Update-DR with ir == IR_ADDR (Capture-DR in the same DR scan determines the shifted-out data):
  - Phase IDLE: word 0x009A → ADDR; 0x009B → WRITE; 0x009D → READ; any other word sets cmd_err and stays IDLE.
  - Phase ADDR: addr = word[7:0]; → IDLE.
  - Phase WRITE: regfile[addr[4:1]] = word; → IDLE.
  - Phase READ: data was already shifted out during this scan; input ignored; → IDLE.
- Address: addr[0] is ignored and addr[7:5] wraps. Example: 0x22 aliases index 1.
- Host port:
  - host_we writes regfile[host_addr] on the clk edge.
  - On the same cycle as a JTAG write to the same index, the JTAG write wins.
  - host_rdata reflects any write on the next cycle.
- Capture happens on the rise that enters Capture-DR. Data latched into the shift register at that point is stable for the scan.

Decomposition:
- Package jtag_pkg holds:
  - TAP state localparams (4-bit encodings);
  - command codes CMD_SET_ADDR = 8'h9A, CMD_WRITE = 8'h9B, CMD_READ = 8'h9D;
  - JTAG_ID default.
- Sub-module jtag_edge_sync holds the synchroniser plus rise/fall pulse generation; one instance covers tck/tms/tdi.

Test Plan:
- Reset checks:
  - Hold reset_n = 0 → tdo = 0, tdo_oe = 0, tap_state = Test-Logic-Reset, ir = 8'h09.
  - Release, then 5 tck rises with tms = 1 → still Test-Logic-Reset.
- IR scan: shift 8'h09 → tdo emits 8'h89 MSB first; after Update-IR, ir = 8'h09, and tdo_oe was high only during the 8 shift bits.
- Read path: host writes index 1 = 16'h0001. Then run IR 0x09; DR 0x009A; DR 0x0002; DR 0x009D; DR 0x0000 → the last scan's tdo bits = 16'h0001.
- Write then read back:
  - DR 0x009A, 0x001C, 0x009B, 0xBEEF → host_addr = 14 gives host_rdata = 16'hBEEF next cycle.
  - A JTAG read of address 0x1C returns 0xBEEF.
- Error and wrap:
  - DR word 0x0055 in IDLE → cmd_err = 1 (sticky through later valid commands).
  - Address 0x22 read → returns index 1 contents.
- Poller loopback: connect to the poller with index 1 = 0x0000 and index 0 = 0x1234 → poll_done pulses and data = 16'h1234. Set index 1 = 0x0001 → the poller loops, and poll_done stays 0.
